// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// width helper used for select and index fields.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   // Ceiling log2, never below 1 so a field width is always legal.
   function automatic int apb_clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: searches the request vector starting one
// past ptr_i, so the most recent winner has the lowest priority.
module apb_rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o
);

   // Scan from the farthest position to the nearest; the nearest requester
   // after the pointer overwrites any earlier hit and therefore wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      for (int off = N; off >= 1; off--) begin
         if (req_i[(int'(ptr_i) + off) % N]) begin
            grant_o = '0;
            grant_o[(int'(ptr_i) + off) % N] = 1'b1;
            idx_o = IW'((int'(ptr_i) + off) % N);
         end
      end
   end

endmodule

// File: rtl/apb_rr_master.sv
// Multi-requester APB master: round-robin arbitration among NREQ requesters,
// IDLE/SETUP/ACCESS bus sequencing, slave-select decode, wait-state timeout
// and a registered one-cycle response pulse to the owning requester.
module apb_rr_master
   import apb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int NSLV    = 4,
   parameter int SLV_LSB = 12,
   parameter int TIMEOUT = 16
) (
   input  logic                   PCLK,
   input  logic                   PRESETn,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_write,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic [ADDR_W-1:0]      PADDR,
   output logic [DATA_W-1:0]      PWDATA,
   output logic                   PWRITE,
   output logic [NSLV-1:0]        PSELx,
   output logic                   PENABLE,
   input  logic [DATA_W-1:0]      PRDATA,
   input  logic                   PREADY,
   input  logic                   PSLVERR
);

   localparam int IW = apb_clog2(NREQ);
   localparam int SW = apb_clog2(NSLV);
   localparam int CW = apb_clog2(TIMEOUT + 1);

   apb_state_e        state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic [NREQ-1:0]   grant;
   logic [IW-1:0]     win_idx;
   logic              accept;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              win_write;
   logic              bus_active;

   apb_rr_picker #(
      .N  (NREQ),
      .IW (IW)
   ) u_picker (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (win_idx)
   );

   // Select the winning requester's command fields from the flattened buses.
   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_write = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == IW'(i)) begin
            win_addr  = req_addr[i*ADDR_W +: ADDR_W];
            win_wdata = req_wdata[i*DATA_W +: DATA_W];
            win_write = req_write[i];
         end
      end
   end

   // Next-state, acceptance and response logic. Acceptance happens in IDLE or
   // in the ACCESS completion cycle, which is what gives back-to-back SETUPs.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      write_d     = write_q;
      cnt_d       = cnt_q;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      accept      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            accept = PRESETn && (|req_valid);
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_rdata_d = write_q ? '0 : PRDATA;
               rsp_err_d   = PSLVERR;
               state_d     = ST_IDLE;
               accept      = PRESETn && (|req_valid);
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // Last permitted wait cycle: abort and report an error.
               rsp_valid_d[owner_q] = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               state_d     = ST_IDLE;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (accept) begin
         state_d = ST_SETUP;
         ptr_d   = win_idx;
         owner_d = win_idx;
         addr_d  = win_addr;
         wdata_d = win_wdata;
         write_d = win_write;
      end
   end

   // State and datapath registers; reset releases the bus and drops any
   // response belonging to an interrupted transfer.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q     <= ST_IDLE;
         ptr_q       <= IW'(NREQ - 1);
         owner_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus_active = (state_q != ST_IDLE);

   // Slave decode from the latched address field (NSLV is at least 2).
   for (genvar gi = 0; gi < NSLV; gi++) begin : g_psel
      assign PSELx[gi] = bus_active && (addr_q[SLV_LSB +: SW] == SW'(gi));
   end

   assign req_ready = accept ? grant : '0;
   assign PENABLE   = (state_q == ST_ACCESS);
   assign PADDR     = addr_q;
   assign PWDATA    = wdata_q;
   assign PWRITE    = write_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: directed scenarios plus a randomized
// run checked against a transaction-level round-robin/APB reference model.
module tb_apb_rr_master;

   logic         PCLK;
   logic         PRESETn;
   logic [3:0]   req_valid;
   logic [3:0]   req_write;
   logic [127:0] req_addr;
   logic [127:0] req_wdata;
   logic [3:0]   req_ready;
   logic [3:0]   rsp_valid;
   logic [31:0]  rsp_rdata;
   logic         rsp_err;
   logic [31:0]  PADDR;
   logic [31:0]  PWDATA;
   logic         PWRITE;
   logic [3:0]   PSELx;
   logic         PENABLE;
   logic [31:0]  PRDATA;
   logic         PREADY;
   logic         PSLVERR;

   int checks = 0;
   int errors = 0;

   apb_rr_master #(
      .NREQ(4), .ADDR_W(32), .DATA_W(32), .NSLV(4), .SLV_LSB(12), .TIMEOUT(16)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
      .PSELx(PSELx), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   task automatic clear_inputs();
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
      req_valid[i] = 1'b1;
      req_write[i] = wr;
      req_addr[i*32 +: 32] = a;
      req_wdata[i*32 +: 32] = d;
   endtask

   task automatic do_reset();
      PRESETn = 1'b0;
      clear_inputs();
      tick();
      tick();
      PRESETn = 1'b1;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      clear_inputs();
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'h0000_1000 * i, 32'h5555_0000 + i);
      PREADY = 1'b1;
      tick();
      checks++; if (PSELx !== 4'b0000) begin errors++; $display("FAIL rst_psel: got %b want 0000", PSELx); end
      checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL rst_penable: got %b want 0", PENABLE); end
      checks++; if ({PADDR, PWDATA, PWRITE} !== 65'd0) begin errors++; $display("FAIL rst_bus: got addr=%h wdata=%h write=%b want zeros", PADDR, PWDATA, PWRITE); end
      checks++; if ({rsp_valid, rsp_rdata, rsp_err} !== 37'd0) begin errors++; $display("FAIL rst_rsp: got valid=%b rdata=%h err=%b want zeros", rsp_valid, rsp_rdata, rsp_err); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
      clear_inputs();
      PRESETn = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_single_read();
      clear_inputs();
      set_req(0, 1'b0, 32'h0000_1004, 32'h0);
      PREADY = 1'b1;
      PRDATA = 32'd16;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rd_ready: got %b want 0001", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (PSELx !== 4'b0010 || PENABLE !== 1'b0) begin errors++; $display("FAIL rd_setup: got psel=%b pen=%b want 0010/0", PSELx, PENABLE); end
      checks++; if (PADDR !== 32'h0000_1004 || PWRITE !== 1'b0) begin errors++; $display("FAIL rd_addr: got %h/%b want 00001004/0", PADDR, PWRITE); end
      tick();
      checks++; if (PSELx !== 4'b0010 || PENABLE !== 1'b1) begin errors++; $display("FAIL rd_access: got psel=%b pen=%b want 0010/1", PSELx, PENABLE); end
      tick();
      checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'd16 || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp: got v=%b d=%h e=%b want 0001/00000010/0", rsp_valid, rsp_rdata, rsp_err); end
      checks++; if (PSELx !== 4'b0000 || PENABLE !== 1'b0) begin errors++; $display("FAIL rd_idle: got psel=%b pen=%b want 0000/0", PSELx, PENABLE); end
      tick();
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rd_pulse: got %b want 0000", rsp_valid); end
      $display("txn req0 read addr=00001004 rdata=%h err=%b", 32'd16, 1'b0);
   endtask

   task automatic test_write_waits();
      clear_inputs();
      set_req(2, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF);
      PRDATA = 32'h1234_5678;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wr_ready: got %b want 0100", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (PSELx !== 4'b1000 || PENABLE !== 1'b0) begin errors++; $display("FAIL wr_setup: got psel=%b pen=%b want 1000/0", PSELx, PENABLE); end
      for (int w = 0; w < 3; w++) begin
         tick();
         checks++; if (PENABLE !== 1'b1 || PSELx !== 4'b1000 || PWDATA !== 32'hDEAD_BEEF || PWRITE !== 1'b1 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_access%0d: got pen=%b psel=%b wdata=%h wr=%b rv=%b want 1/1000/deadbeef/1/0000", w, PENABLE, PSELx, PWDATA, PWRITE, rsp_valid); end
         PREADY = (w == 2);
      end
      tick();
      PREADY = 1'b0;
      checks++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp: got v=%b d=%h e=%b want 0100/00000000/0", rsp_valid, rsp_rdata, rsp_err); end
      checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL wr_pen_drop: got %b want 0", PENABLE); end
      $display("txn req2 write addr=00003000 wdata=deadbeef err=0");
   endtask

   task automatic test_round_robin();
      logic [3:0] e;
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, (32'h1000 * i) | (32'h10 * i), 32'h0);
      PREADY = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first: got %b want 0001", req_ready); end
      for (int k = 0; k <= 4; k++) begin
         tick();
         e = 4'(1 << (k % 4));
         checks++; if (PENABLE !== 1'b0 || PSELx !== e || req_ready !== 4'b0000) begin errors++; $display("FAIL rr_setup%0d: got pen=%b psel=%b rdy=%b want 0/%b/0000", k, PENABLE, PSELx, req_ready, e); end
         checks++; if (PADDR !== ((32'h1000 * (k % 4)) | (32'h10 * (k % 4)))) begin errors++; $display("FAIL rr_addr%0d: got %h", k, PADDR); end
         if (k > 0) begin
            checks++; if (rsp_valid !== 4'(1 << ((k - 1) % 4)) || rsp_rdata !== 32'hC0DE_0000 + k - 1) begin errors++; $display("FAIL rr_rsp%0d: got v=%b d=%h", k, rsp_valid, rsp_rdata); end
            $display("txn req%0d read rdata=%h err=%b", (k - 1) % 4, rsp_rdata, rsp_err);
         end
         if (k == 4) req_valid = '0;
         PRDATA = 32'hC0DE_0000 + k;
         tick();
         checks++; if (PENABLE !== 1'b1 || PSELx !== e) begin errors++; $display("FAIL rr_access%0d: got pen=%b psel=%b want 1/%b", k, PENABLE, PSELx, e); end
         #1;
         e = (k < 4) ? 4'(1 << ((k + 1) % 4)) : 4'b0000;
         checks++; if (req_ready !== e) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k + 1, req_ready, e); end
      end
      tick();
      checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'hC0DE_0004 || PSELx !== 4'b0000) begin errors++; $display("FAIL rr_last: got v=%b d=%h psel=%b", rsp_valid, rsp_rdata, PSELx); end
      $display("txn req0 read rdata=%h err=%b", rsp_rdata, rsp_err);
      clear_inputs();
   endtask

   task automatic test_timeout();
      clear_inputs();
      set_req(3, 1'b0, 32'h0000_2000, 32'h0);
      PRDATA = 32'hFFFF_FFFF;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL to_ready: got %b want 1000", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (PSELx !== 4'b0100 || PENABLE !== 1'b0) begin errors++; $display("FAIL to_setup: got psel=%b pen=%b", PSELx, PENABLE); end
      for (int a = 0; a < 16; a++) begin
         tick();
         checks++; if (PENABLE !== 1'b1 || PSELx !== 4'b0100 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL to_access%0d: got pen=%b psel=%b rv=%b want 1/0100/0000", a, PENABLE, PSELx, rsp_valid); end
      end
      tick();
      checks++; if (PSELx !== 4'b0000 || PENABLE !== 1'b0) begin errors++; $display("FAIL to_release: got psel=%b pen=%b want 0000/0", PSELx, PENABLE); end
      checks++; if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL to_rsp: got v=%b e=%b d=%h want 1000/1/00000000", rsp_valid, rsp_err, rsp_rdata); end
      $display("txn req3 read addr=00002000 timeout err=%b", rsp_err);
   endtask

   task automatic test_slverr();
      clear_inputs();
      set_req(1, 1'b0, 32'h0000_0004, 32'h0);
      PREADY = 1'b1;
      PSLVERR = 1'b1;
      PRDATA = 32'hA5A5_0001;
      tick();
      req_valid = '0;
      tick();
      tick();
      checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL slverr_rsp: got v=%b e=%b d=%h want 0010/1/a5a50001", rsp_valid, rsp_err, rsp_rdata); end
      $display("txn req1 read addr=00000004 rdata=%h err=%b", rsp_rdata, rsp_err);
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      set_req(1, 1'b0, 32'h0000_1000, 32'h0);
      tick();
      req_valid = '0;
      tick();
      tick();
      checks++; if (PENABLE !== 1'b1 || PSELx !== 4'b0010) begin errors++; $display("FAIL rm_access: got pen=%b psel=%b want 1/0010", PENABLE, PSELx); end
      PRESETn = 1'b0;
      PREADY = 1'b1;
      set_req(0, 1'b0, 32'h0000_0010, 32'h0);
      set_req(1, 1'b0, 32'h0000_1010, 32'h0);
      set_req(2, 1'b0, 32'h0000_2010, 32'h0);
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready_rst: got %b want 0000", req_ready); end
      tick();
      checks++; if (PSELx !== 4'b0000 || PENABLE !== 1'b0 || PADDR !== 32'd0 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_cleared: got psel=%b pen=%b addr=%h rv=%b", PSELx, PENABLE, PADDR, rsp_valid); end
      PRESETn = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first: got %b want 0001", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (rsp_valid !== 4'b0000 || PSELx !== 4'b0001) begin errors++; $display("FAIL rm_after: got rv=%b psel=%b want 0000/0001", rsp_valid, PSELx); end
      tick();
      tick();
      checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rm_rsp: got %b want 0001", rsp_valid); end
      $display("txn req0 read addr=00000010 after reset err=%b", rsp_err);
      clear_inputs();
      tick();
   endtask

   task automatic test_random();
      int phase, cur_req, wait_left, last, rsp_owner, exp_g, c;
      logic cur_wr, rsp_pend, rsp_e, rsp_wr;
      logic [31:0] cur_addr, cur_wdata, rsp_rd, rsp_addr;
      logic pv[4];
      logic pw[4];
      logic [31:0] pa[4];
      logic [31:0] pd[4];
      logic [3:0] exp_sel, exp_rdy;
      do_reset();
      phase = 0; last = 3; rsp_pend = 1'b0; wait_left = 0;
      cur_req = 0; cur_wr = 1'b0; cur_addr = '0; cur_wdata = '0;
      rsp_owner = 0; rsp_e = 1'b0; rsp_rd = '0; rsp_addr = '0; rsp_wr = 1'b0;
      for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
      for (int cyc = 0; cyc < 420; cyc++) begin
         if (rsp_pend) begin
            checks++; if (rsp_valid !== 4'(1 << rsp_owner) || rsp_rdata !== rsp_rd || rsp_err !== rsp_e) begin errors++; $display("FAIL rnd_rsp cyc%0d: got v=%b d=%h e=%b want %b/%h/%b", cyc, rsp_valid, rsp_rdata, rsp_err, 4'(1 << rsp_owner), rsp_rd, rsp_e); end
            $display("txn req%0d %s addr=%h rdata=%h err=%b", rsp_owner, rsp_wr ? "write" : "read", rsp_addr, rsp_rdata, rsp_err);
         end else begin
            checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rnd_idle_rsp cyc%0d: got %b want 0000", cyc, rsp_valid); end
         end
         exp_sel = (phase == 0) ? 4'b0000 : 4'(1 << cur_addr[13:12]);
         checks++; if (PSELx !== exp_sel || PENABLE !== (phase == 2)) begin errors++; $display("FAIL rnd_bus cyc%0d: got psel=%b pen=%b want %b/%b", cyc, PSELx, PENABLE, exp_sel, phase == 2); end
         if (phase != 0) begin
            checks++; if (PADDR !== cur_addr || PWRITE !== cur_wr || (cur_wr && PWDATA !== cur_wdata)) begin errors++; $display("FAIL rnd_cmd cyc%0d: got %h/%b/%h want %h/%b/%h", cyc, PADDR, PWRITE, PWDATA, cur_addr, cur_wr, cur_wdata); end
         end
         for (int i = 0; i < 4; i++) begin
            if (!pv[i] && cyc < 400 && $urandom_range(0, 2) == 0) begin
               pv[i] = 1'b1;
               pw[i] = 1'($urandom_range(0, 1));
               pa[i] = ($urandom & 32'hFFFF_0FFC) | (32'($urandom_range(0, 3)) << 12);
               pd[i] = $urandom;
            end
            req_valid[i] = pv[i];
            req_write[i] = pw[i];
            req_addr[i*32 +: 32] = pa[i];
            req_wdata[i*32 +: 32] = pd[i];
         end
         PRDATA = $urandom;
         if (phase == 2) begin
            PREADY = (wait_left == 0);
            PSLVERR = ($urandom_range(0, 7) == 0);
         end else begin
            PREADY = 1'($urandom_range(0, 1));
            PSLVERR = 1'($urandom_range(0, 1));
         end
         #1;
         exp_g = -1;
         if (phase == 0 || (phase == 2 && PREADY)) begin
            for (int off = 1; off <= 4; off++) begin
               c = (last + off) % 4;
               if (exp_g < 0 && pv[c]) exp_g = c;
            end
         end
         exp_rdy = (exp_g >= 0) ? 4'(1 << exp_g) : 4'b0000;
         checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, req_ready, exp_rdy); end
         rsp_pend = (phase == 2) && PREADY;
         if (rsp_pend) begin
            rsp_owner = cur_req; rsp_wr = cur_wr; rsp_addr = cur_addr;
            rsp_rd = cur_wr ? 32'd0 : PRDATA;
            rsp_e = PSLVERR;
         end
         if (phase == 2 && !PREADY) wait_left--;
         if (exp_g >= 0) begin
            cur_req = exp_g; cur_wr = pw[exp_g]; cur_addr = pa[exp_g]; cur_wdata = pd[exp_g];
            pv[exp_g] = 1'b0;
            last = exp_g;
            wait_left = $urandom_range(0, 3);
            phase = 1;
         end else if (phase == 1) begin
            phase = 2;
         end else if (phase == 2 && PREADY) begin
            phase = 0;
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      PRESETn = 1'b0;
      clear_inputs();
      @(negedge PCLK);
      test_reset();
      test_single_read();
      test_write_waits();
      test_round_robin();
      test_timeout();
      test_slverr();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Multi-requester APB master: arbitrates round-robin among NREQ local requesters and sequences the single shared APB bus through IDLE/SETUP/ACCESS phases. Decodes the slave select from the address and applies a wait-state timeout. Returns read data and error per transfer. Sits between the team's bus-request sources and the APB slave fabric, replacing single-requester use of the existing apb master.

## Interface
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NSLV, 4, number of slaves, power of two
- SLV_LSB, 12, lowest PADDR bit of the slave-select field (width log2(NSLV))
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort
- PCLK  in  1  single clock, rising edge
- PRESETn  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester transfer request
- req_write  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  flattened, same packing
- req_ready  out  NREQ  one-hot accept; transfer accepted when valid&ready
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse to owning requester
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid (0 for writes/errors)
- rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid
- PADDR  out  ADDR_W; PWDATA  out  DATA_W; PWRITE  out  1
- PSELx  out  NSLV  one-hot slave select
- PENABLE  out  1
- PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: PSELx=0, PENABLE=0. If any req_valid, req_ready is driven combinationally to the round-robin winner. Next edge: latch addr/wdata/write/owner, update pointer, go SETUP.
- Round-robin: priority starts at ptr+1 mod NREQ. ptr becomes the winner index on accept. Reset ptr=NREQ-1, so req 0 wins first.
- SETUP: exactly one cycle, PSELx[PADDR[SLV_LSB +: log2 NSLV]]=1, PENABLE=0. Go ACCESS.
- ACCESS: PENABLE=1, PSELx/PADDR/PWDATA/PWRITE held stable. Wait counter increments each cycle PREADY=0.
- Completion occurs on a cycle with PREADY=1 in ACCESS:
  - rdata is registered: PRDATA for reads, 0 for writes.
  - err is registered as PSLVERR.
  - rsp_valid[owner] pulses in the next cycle.
- Timeout: when the counter reaches TIMEOUT with PREADY still 0, abort. Drop PSEL/PENABLE, then rsp_err=1 and rsp_rdata=0 with the pulse.
- Back-to-back: in the completion cycle, if any req_valid is high, req_ready is driven to the next winner. The FSM goes directly to SETUP; PSELx stays asserted and PENABLE drops. Otherwise it goes to IDLE.
- req_ready is never asserted in SETUP, or in ACCESS before completion.
- Requesters may drop req_valid before acceptance without effect.

## Timing
- Reset (PRESETn=0 at an edge) forces:
  - state=IDLE, ptr=NREQ-1, counter=0
  - PSELx=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - req_ready=0 while PRESETn=0
- Reset mid-transfer: the bus is released at that edge and no rsp_valid is issued for the aborted transfer.
- Zero-wait latency: accept at edge T0, SETUP in cycle T0..T1, ACCESS in T1..T2 with PREADY=1, rsp_valid in T2..T3.
  - Accept to response is 3 cycles.
  - Back-to-back bus throughput is 1 transfer per 2 cycles.
- Each wait state adds 1 cycle. A timeout aborts after TIMEOUT ACCESS cycles; response follows 1 cycle later.
- Simultaneous requests in the same cycle: exactly one winner by pointer order. Losers hold req_valid.

## Structure
- Shared package apb_pkg:
  - state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2)
  - default ADDR_W/DATA_W
  - the clog2 helper for the slave-select width
- Sub-module apb_rr_picker (combinational): inputs req vector and ptr; outputs one-hot grant and encoded index. Reused by other arbiters in the codebase.
- Top holds the FSM, latch registers, wait counter, address decoder and response registers.

## Test plan
- Single read, zero wait:
  - Stimulus: req0 read 0x0000_1004, PREADY=1 in first ACCESS, PRDATA=32'd16.
  - Response: PSELx=4'b0010 for 2 cycles, then rsp_valid=4'b0001, rsp_rdata=16, rsp_err=0.
- Write with 2 wait states:
  - Stimulus: req2 write 0x0000_3000 / 0xDEADBEEF, PREADY low 2 cycles.
  - Response: PSELx=4'b1000, PENABLE high 3 cycles, PWDATA stable, rsp_valid=4'b0100 5 cycles after accept.
- All four requesters held valid from reset:
  - Grant order 0,1,2,3,0.
  - Transfers are back-to-back with no IDLE cycle between them.
  - PENABLE toggles 0/1 each cycle.
- Timeout:
  - Stimulus: TIMEOUT=16, PREADY held 0.
  - Response: bus released after 16 ACCESS cycles, then rsp_err=1 and rsp_rdata=0.
- PSLVERR=1 with PREADY on a read: rsp_err=1 and rsp_rdata=PRDATA.
- Reset mid-ACCESS:
  - Stimulus: PRESETn=0 while a req1 transfer is in ACCESS.
  - Response: all outputs 0 the next edge, no rsp_valid; after release, req0 wins first.
